// File: rtl/demux4_stream_dispatcher_pkg.sv
// Shared constants and the round-robin search helper for the 1:4 stream dispatcher.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    // Returns {found, idx}: the first free channel searching ptr, ptr+1, ... mod NUM_CH.
    function automatic logic [SEL_W:0] next_rr(input logic [SEL_W-1:0] ptr,
                                               input logic [NUM_CH-1:0] free);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (free[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/demux4_stream_dispatcher_if.sv
// Stream-side bundle of the dispatcher: one producer port and four consumer lanes.
// Handshake: a beat moves when valid & ready are both high on a rising edge; valid and
// data are held stable by the sender until that happens, and ready never depends on valid.
interface demux4_stream_dispatcher_if #(parameter int DW = 8);
    import demux4_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_data;
    logic [SEL_W-1:0]       in_sel;
    logic [NUM_CH-1:0]      out_valid;
    logic [NUM_CH-1:0]      out_ready;
    logic [NUM_CH*DW-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux4_stream_dispatcher_slot.sv
// One-entry output register: loads a beat, drains on consumer ready, can do both in one cycle.
module dispatch_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          drain,
    output logic          valid,
    output logic [DW-1:0] dout,
    output logic          free
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= din;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;
    assign free  = !valid_q || drain;

endmodule

// File: rtl/demux4_stream_dispatcher.sv
// 1:4 stream dispatcher: directed or round-robin routing into registered output slots,
// with a saturating beat counter per channel.
module demux4_stream_dispatcher
    import demux4_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     clr_cnt,
    demux4_stream_dispatcher_if.slave s,
    output logic [NUM_CH*CNTW-1:0]   beat_cnt,
    output logic [SEL_W-1:0]         dbg_ptr
);

    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic [SEL_W:0]    rr_pick;
    logic [SEL_W-1:0]  target;
    logic              accept;
    logic [SEL_W-1:0]  ptr_q;
    logic [CNTW-1:0]   cnt_q [NUM_CH];

    // Directed mode only looks at its own lane, so a full lane blocks the producer.
    always_comb begin
        rr_pick = next_rr(ptr_q, free);
        if (mode == MODE_RR) begin
            target     = rr_pick[SEL_W-1:0];
            s.in_ready = rr_pick[SEL_W];
        end else begin
            target     = s.in_sel;
            s.in_ready = free[s.in_sel];
        end
        accept = s.in_valid && s.in_ready;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = accept && (target == SEL_W'(i));

        dispatch_slot #(.DW(DW)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .din   (s.in_data),
            .drain (s.out_ready[i]),
            .valid (s.out_valid[i]),
            .dout  (s.out_data[i*DW +: DW]),
            .free  (free[i])
        );

        assign beat_cnt[i*CNTW +: CNTW] = cnt_q[i];
    end

    // The pointer only advances on round-robin accepts and survives mode switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept && mode == MODE_RR) begin
            ptr_q <= target + 1'b1;
        end
    end

    // Clear wins over a same-cycle accept; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
        end else if (clr_cnt) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
        end else if (accept && cnt_q[target] != '1) begin
            cnt_q[target] <= cnt_q[target] + 1'b1;
        end
    end

    assign dbg_ptr = ptr_q;

endmodule

// File: tb/tb_demux4_stream_dispatcher.sv
// Directed-vector bench for demux4_stream_dispatcher, built with CNTW=2 to reach saturation quickly.
module tb_demux4_stream_dispatcher;

    localparam int DW   = 8;
    localparam int CNTW = 2;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic             clr_cnt;
    logic [4*CNTW-1:0] beat_cnt;
    logic [1:0]       dbg_ptr;

    int errors = 0;
    int checks = 0;

    demux4_stream_dispatcher_if #(.DW(DW)) bus ();

    demux4_stream_dispatcher #(.DW(DW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .clr_cnt  (clr_cnt),
        .s        (bus.slave),
        .beat_cnt (beat_cnt),
        .dbg_ptr  (dbg_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 4'b0000;
        clr_cnt       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 4'b0000 || beat_cnt !== 8'h00 || dbg_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: out_valid=%b beat_cnt=%h ptr=%0d, want 0000/00/0",
                     bus.out_valid, beat_cnt, dbg_ptr);
        end
        // Park beats on ch1 and ch3, then yank reset mid-cycle.
        mode = 1'b0; bus.out_ready = 4'b0000; bus.in_valid = 1'b1;
        bus.in_sel = 2'd1; bus.in_data = 8'hC1; step();
        bus.in_sel = 2'd3; bus.in_data = 8'hC3; step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b1010) begin
            errors++;
            $display("FAIL reset_preload: out_valid=%b want 1010", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000 || beat_cnt !== 8'h00 || dbg_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b beat_cnt=%h ptr=%0d, want 0000/00/0",
                     bus.out_valid, beat_cnt, dbg_ptr);
        end
        #1;
        rst_n = 1'b1;
        step();
        mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b0001 || bus.out_data[7:0] !== 8'hA5 || dbg_ptr !== 2'd1) begin
            errors++;
            $display("FAIL reset_first_rr: out_valid=%b d0=%h ptr=%0d, want 0001/a5/1",
                     bus.out_valid, bus.out_data[7:0], dbg_ptr);
        end
        step();
    endtask

    task automatic test_directed();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        clear_counts();
        mode = 1'b0; bus.in_sel = 2'd2; bus.out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = vals[i];
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_ready beat%0d: in_ready=%b want 1", i, bus.in_ready);
            end
            step();
            checks++;
            if (bus.out_valid !== 4'b0100 || bus.out_data[23:16] !== vals[i]) begin
                errors++;
                $display("FAIL directed_beat%0d: out_valid=%b d2=%h, want 0100/%h",
                         i, bus.out_valid, bus.out_data[23:16], vals[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 4'b0000 || beat_cnt !== 8'h30) begin
            errors++;
            $display("FAIL directed_end: out_valid=%b beat_cnt=%h, want 0000/30",
                     bus.out_valid, beat_cnt);
        end
    endtask

    task automatic test_directed_blocking();
        clear_counts();
        mode = 1'b0; bus.in_sel = 2'd1; bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_data = 8'h44;
        step();
        bus.in_data = 8'h55;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL block_ready_low: in_ready=%b want 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[15:8] !== 8'h44) begin
            errors++;
            $display("FAIL block_hold: out_valid=%b d1=%h, want 0010/44",
                     bus.out_valid, bus.out_data[15:8]);
        end
        bus.out_ready = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL block_ready_high: in_ready=%b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[15:8] !== 8'h55 || beat_cnt !== 8'h08) begin
            errors++;
            $display("FAIL block_refill: out_valid=%b d1=%h cnt=%h, want 0010/55/08",
                     bus.out_valid, bus.out_data[15:8], beat_cnt);
        end
        bus.out_ready = 4'b1111;
        step();
    endtask

    task automatic test_rr_wrap();
        logic [3:0] exp_v;
        logic [1:0] exp_ch;
        logic [7:0] got;
        do_reset();
        mode = 1'b1; bus.out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_ch = 2'(i % 4);
            exp_v  = 4'b0001 << exp_ch;
            bus.in_valid = 1'b1; bus.in_data = 8'h80 + 8'(i);
            step();
            got = bus.out_data[exp_ch*8 +: 8];
            checks++;
            if (bus.out_valid !== exp_v || got !== 8'h80 + 8'(i) || dbg_ptr !== 2'(exp_ch + 1)) begin
                errors++;
                $display("FAIL rr_beat%0d: out_valid=%b data=%h ptr=%0d, want %b/%h/%0d",
                         i, bus.out_valid, got, dbg_ptr, exp_v, 8'h80 + 8'(i), 2'(exp_ch + 1));
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_rr_skip();
        do_reset();
        mode = 1'b1; bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_data = 8'h60;
        step();
        // Fill ch1 and ch2 in directed mode so ptr stays at 1.
        mode = 1'b0;
        bus.in_sel = 2'd1; bus.in_data = 8'h61; step();
        bus.in_sel = 2'd2; bus.in_data = 8'h62; step();
        mode = 1'b1; bus.in_data = 8'h66;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || dbg_ptr !== 2'd1) begin
            errors++;
            $display("FAIL skip_pre: in_ready=%b ptr=%0d, want 1/1", bus.in_ready, dbg_ptr);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b1111 || bus.out_data[31:24] !== 8'h66 || dbg_ptr !== 2'd0) begin
            errors++;
            $display("FAIL skip_to_ch3: out_valid=%b d3=%h ptr=%0d, want 1111/66/0",
                     bus.out_valid, bus.out_data[31:24], dbg_ptr);
        end
        bus.in_data = 8'h67;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skip_all_full: in_ready=%b want 0", bus.in_ready);
        end
        step();
        checks++;
        if (dbg_ptr !== 2'd0 || bus.out_data[7:0] !== 8'h60 || bus.out_data[31:24] !== 8'h66) begin
            errors++;
            $display("FAIL skip_stall_hold: ptr=%0d d0=%h d3=%h, want 0/60/66",
                     dbg_ptr, bus.out_data[7:0], bus.out_data[31:24]);
        end
        bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
        step();
    endtask

    task automatic test_counters();
        do_reset();
        mode = 1'b0; bus.in_sel = 2'd0; bus.out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(i);
            step();
        end
        checks++;
        if (beat_cnt !== 8'h03) begin
            errors++;
            $display("FAIL cnt_saturate: beat_cnt=%h want 03", beat_cnt);
        end
        clr_cnt = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'h77;
        step();
        clr_cnt = 1'b0;
        checks++;
        if (beat_cnt !== 8'h00 || bus.out_valid !== 4'b0100 || bus.out_data[23:16] !== 8'h77) begin
            errors++;
            $display("FAIL cnt_clear_accept: cnt=%h out_valid=%b d2=%h, want 00/0100/77",
                     beat_cnt, bus.out_valid, bus.out_data[23:16]);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (beat_cnt !== 8'h10) begin
            errors++;
            $display("FAIL cnt_after_clear: beat_cnt=%h want 10", beat_cnt);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        idle_inputs();
        #12;
        rst_n = 1'b1;
        step();
        test_reset();
        test_directed();
        test_directed_blocking();
        test_rr_wrap();
        test_rr_skip();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
